buf_writer: RTL
===============

BUF_WRITER -- requirements
Module: buf_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 2, symbol width in bits (bits per QPSK symbol); only 2 is supported.
REQ-002 Parameter ADDR_WIDTH, default 11, buffer address width; frame length is 2**ADDR_WIDTH symbols.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  global enable; when low, all state and outputs except wr_en, frame_done and overflow hold; wr_en and frame_done are 0.
REQ-006 start  input  1  one-cycle request to begin filling a frame.
REQ-007 bit_in  input  1  serial payload bit.
REQ-008 valid_bit  input  1  bit_in is valid this cycle.
REQ-009 release  input  1  one-cycle pulse from the reader side: frame consumed, buffer may be refilled.
REQ-010 ready_bit  output  1  high when a valid bit will be accepted this cycle (state FILL and en high).
REQ-011 wr_en  output  1  one-cycle write strobe to the buffer memory.
REQ-012 wr_addr  output  ADDR_WIDTH  write address.
REQ-013 wr_data  output  DATA_WIDTH  packed symbol to write.
REQ-014 frame_done  output  1  one-cycle pulse when the last symbol of a frame is written.
REQ-015 buf_full  output  1  high in state FULL; the reader may then issue addresses.
REQ-016 overflow  output  1  sticky flag: a valid bit arrived while ready_bit was low.

Function
REQ-017 FSM states: IDLE, FILL, FULL.
REQ-018 IDLE -> FILL when start=1 and en=1; wr_addr and the half-symbol register are cleared on this transition.
REQ-019 In FILL, an accepted bit is a bit with valid_bit=1 and ready_bit=1.
REQ-020 Packing is MSB-first: the first accepted bit of a pair goes to bit 1, the second to bit 0.
REQ-021 On the cycle after the second bit of a pair is accepted: wr_en=1, wr_data=pair, wr_addr=current address (write latency 1 cycle).
REQ-022 wr_addr increments by 1 after each write; it does not wrap inside a frame.
REQ-023 When the write at address 2**ADDR_WIDTH-1 is issued, frame_done=1 on the same cycle and the FSM enters FULL on the next cycle.
REQ-024 In FULL, ready_bit=0 and buf_full=1; release=1 with en=1 -> IDLE with wr_addr=0.
REQ-025 start is ignored outside IDLE, and release is ignored outside FULL.
REQ-026 Gaps in valid_bit are allowed; a held half-symbol waits indefinitely for its partner bit.
REQ-027 A valid_bit=1 while ready_bit=0 sets overflow; the bit is discarded, and overflow clears only on reset.
REQ-028 If start and valid_bit are both asserted in the IDLE cycle, the bit is not accepted and overflow is set.
REQ-029 If en falls between the two bits of a pair, the half-symbol is retained.

Reset
REQ-030 On rst=0, asynchronously: state=IDLE, wr_addr=0, wr_data=0, wr_en=0, frame_done=0, buf_full=0, overflow=0, ready_bit=0, and the half-symbol register is cleared.
REQ-031 A reset asserted mid-FILL discards the partial frame and any half-symbol; no write is issued for it.

Structure
REQ-032 A shared package buf_pkg holds the DATA_WIDTH and ADDR_WIDTH defaults and the FSM state encoding.
REQ-033 Bit packing lives in one sub-module, bit_pair_packer (inputs: bit, valid, clear; outputs: pair, pair_valid).
REQ-034 The memory is external; buf_writer only drives the write port.

Verification (bench with ADDR_WIDTH=2, i.e. 4 symbols)
REQ-035 Start, then bits 1,0,0,1,1,1,0,0 on consecutive cycles -> writes (addr 0,data 10),(1,01),(2,11),(3,00); frame_done on the addr-3 write; buf_full high on the next cycle.
REQ-036 In FULL, drive valid_bit=1 -> no write, overflow=1; release -> IDLE; start -> refill begins at addr 0.
REQ-037 Bits 1, gap of 5 cycles, 1 -> single write (addr 0, data 11) one cycle after the second bit.
REQ-038 en=0 after the first bit of a pair for 3 cycles, then en=1 and second bit 0 -> write data 10 at addr 0; no wr_en during en=0.
REQ-039 rst=0 after 3 bits of a frame -> all outputs are at reset values immediately; after rst=1, start and bits 0,1 -> write (addr 0, data 01).
REQ-040 start with valid_bit=1 in the same IDLE cycle -> bit dropped, overflow=1; the following bits pack from addr 0.

Source files
------------

// File: rtl/buf_pkg.sv
// Shared defaults and FSM state encoding for the QPSK frame buffer writer.
package buf_pkg;

  localparam int DATA_WIDTH_DEF = 2;
  localparam int ADDR_WIDTH_DEF = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } state_t;

endpackage

// File: rtl/buf_writer_if.sv
// Bit-input handshake, buffer write port and status flags of buf_writer.
interface buf_writer_if #(
  parameter int DATA_WIDTH = buf_pkg::DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = buf_pkg::ADDR_WIDTH_DEF
) ();

  logic                  en;
  logic                  start;
  logic                  bit_in;
  logic                  valid_bit;
  logic                  release_req;
  logic                  ready_bit;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  frame_done;
  logic                  buf_full;
  logic                  overflow;
  buf_pkg::state_t       dbg_state;

  // A bit transfers on a rising edge where valid_bit and ready_bit are both
  // high; valid_bit with ready_bit low drops the bit and sets sticky overflow.
  modport master (
    output en, start, bit_in, valid_bit, release_req,
    input  ready_bit, wr_en, wr_addr, wr_data, frame_done, buf_full,
           overflow, dbg_state
  );

  modport slave (
    input  en, start, bit_in, valid_bit, release_req,
    output ready_bit, wr_en, wr_addr, wr_data, frame_done, buf_full,
           overflow, dbg_state
  );

endinterface

// File: rtl/bit_pair_packer.sv
// Packs serial bits MSB-first into 2-bit symbols; a lone half-symbol is held.
module bit_pair_packer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_bit,
  input  logic       i_valid,
  input  logic       i_clear,
  output logic [1:0] o_pair,
  output logic       o_pair_valid
);

  logic r_half_valid;
  logic r_half_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_half_valid <= 1'b0;
      r_half_bit   <= 1'b0;
    end else if (i_clear) begin
      r_half_valid <= 1'b0;
      r_half_bit   <= 1'b0;
    end else if (i_valid) begin
      if (r_half_valid) begin
        r_half_valid <= 1'b0;
      end else begin
        r_half_valid <= 1'b1;
        r_half_bit   <= i_bit;
      end
    end
  end

  // The completing bit is combined combinationally so the caller can register it.
  assign o_pair       = {r_half_bit, i_bit};
  assign o_pair_valid = i_valid & r_half_valid & ~i_clear;

endmodule

// File: rtl/buf_writer.sv
// Fills an external symbol buffer one frame at a time from a serial bit stream,
// then holds it full until the reader releases it.
module buf_writer
  import buf_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input logic         clk,
  input logic         rst,
  buf_writer_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_wr_pend;
  logic                  r_overflow;

  logic       w_ready;
  logic       w_accept;
  logic       w_clear;
  logic       w_issue;
  logic [1:0] w_pair;
  logic       w_pair_valid;

  assign w_ready  = (r_state == ST_FILL) & bus.en;
  assign w_accept = bus.valid_bit & w_ready;
  assign w_clear  = (r_state == ST_IDLE) & bus.start & bus.en;
  // A completed symbol waits in r_wr_pend through any en=0 stretch.
  assign w_issue  = r_wr_pend & bus.en;

  bit_pair_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_bit        (bus.bit_in),
    .i_valid      (w_accept),
    .i_clear      (w_clear),
    .o_pair       (w_pair),
    .o_pair_valid (w_pair_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_pend  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (bus.valid_bit && !w_ready) r_overflow <= 1'b1;
      if (bus.en) begin
        if (w_issue) r_wr_pend <= 1'b0;
        if (w_pair_valid) begin
          r_wr_pend <= 1'b1;
          r_wr_data <= w_pair;
        end
        case (r_state)
          ST_IDLE: begin
            if (bus.start) begin
              r_state   <= ST_FILL;
              r_wr_addr <= '0;
            end
          end
          ST_FILL: begin
            if (w_issue) begin
              if (r_wr_addr == LAST_ADDR) r_state <= ST_FULL;
              else                        r_wr_addr <= r_wr_addr + 1'b1;
            end
          end
          ST_FULL: begin
            if (bus.release_req) begin
              r_state   <= ST_IDLE;
              r_wr_addr <= '0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.ready_bit  = w_ready;
  assign bus.wr_en      = w_issue;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.frame_done = w_issue & (r_wr_addr == LAST_ADDR);
  assign bus.buf_full   = (r_state == ST_FULL);
  assign bus.overflow   = r_overflow;
  assign bus.dbg_state  = r_state;

endmodule
